// File: rtl/rnn_pkg.sv
// Shared types and defaults for the RNN bias loader.
// State encoding and default geometry live here.
package rnn_pkg;

  localparam int NUM_BIAS_DEF = 32;
  localparam int BIAS_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rnn_bias_ram.sv
// Bias storage: one write port, one registered read port.
// The output register zeroes on reset or on a flagged bad address.
module rnn_bias_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 16,
  parameter int AW    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  input  logic             i_rzero,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Array write, kept free of reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: loads only on an accepted read, else holds.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rnn_bias_loader.sv
// Loads NUM_BIAS bias words, tracks a running checksum,
// and serves 1-cycle registered reads once fully loaded.
module rnn_bias_loader
  import rnn_pkg::*;
#(
  parameter int NUM_BIAS = NUM_BIAS_DEF,
  parameter int BIAS_W   = BIAS_W_DEF,
  localparam int AW = (NUM_BIAS > 1) ? $clog2(NUM_BIAS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BIAS_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [BIAS_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              loaded,
  output logic [BIAS_W-1:0] checksum
);

  state_t            r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [BIAS_W-1:0] r_sum;
  logic              r_rd_valid;

  logic w_xfer;
  logic w_we;
  logic w_last;
  logic w_rd;
  logic w_rd_bad;

  // in_ready comes straight from state, never from in_valid.
  assign in_ready = (r_state == ST_LOAD);
  assign loaded   = (r_state == ST_DONE);
  assign checksum = r_sum;
  assign rd_valid = r_rd_valid;

  // start wins over a same-cycle word; reset blocks any write.
  assign w_xfer   = in_valid && in_ready && !start;
  assign w_we     = w_xfer && rst_n;
  assign w_last   = (r_wr_ptr == AW'(NUM_BIAS - 1));
  assign w_rd     = rd_en && loaded;
  assign w_rd_bad = ({1'b0, rd_addr} >= (AW + 1)'(NUM_BIAS));

  // Load sequencing: state, write pointer and checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_sum    <= '0;
    end else if (start) begin
      r_state  <= ST_LOAD;
      r_wr_ptr <= '0;
      r_sum    <= '0;
    end else if (w_xfer) begin
      r_wr_ptr <= w_last ? '0 : r_wr_ptr + 1'b1;
      r_sum    <= r_sum + in_data;
      if (w_last) begin
        r_state <= ST_DONE;
      end
    end
  end

  // Read-valid tracks the data register one cycle behind rd_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
    end
  end

  rnn_bias_ram #(
    .DEPTH (NUM_BIAS),
    .WIDTH (BIAS_W),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (in_data),
    .i_re    (w_rd),
    .i_raddr (rd_addr),
    .i_rzero (w_rd_bad),
    .o_rdata (rd_data)
  );

endmodule
